fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_pkg.sv | 29 ++
 rtl/fwd_port_sel.sv | 37 +++
 rtl/fwd_scoreboard.sv | 103 ++++++++++
 tb/tb_fwd_scoreboard.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants and types for the forwarding/hazard scoreboard.
package fwd_scoreboard_pkg;

  // GPR address width and the link register written by jal.
  localparam int               REG_W   = 5;
  localparam logic [REG_W-1:0] RA_ADDR = 5'd31;

  // Stage indices after D.
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  // Forwarding select encodings: 0 reads the register file, k takes stage k.
  localparam int SEL_RF = 0;
  localparam int SEL_E  = STG_E;
  localparam int SEL_M  = STG_M;
  localparam int SEL_W  = STG_W;

  // First stage index at which a result exists (1 jal, 2 ALU, 3 load).
  typedef logic [2:0] ready_t;

  // Shadow copy of a producer travelling down the pipe.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wr_addr;
    ready_t           ready;
  } stage_entry_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port producer search: picks the nearest matching stage and
// reports whether that producer's result is not yet available.
module fwd_port_sel
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = 2
) (
  input  logic [REG_W-1:0]                  rd_addr,
  input  logic                              rd_used,
  input  logic [NUM_STAGES-1:0]             ent_valid,
  input  logic [NUM_STAGES-1:0][REG_W-1:0]  ent_addr,
  input  ready_t [NUM_STAGES-1:0]           ent_ready,
  output logic [SEL_W-1:0]                  sel,
  output logic                              hazard
);

  // Scan from E outward; the first hit is the youngest producer and wins.
  always_comb begin
    logic found;
    // NOTE: every output gets a default before the loop, otherwise paths
    // with no match would hold the old value and infer a latch.
    found  = 1'b0;
    sel    = SEL_W'(SEL_RF);
    hazard = 1'b0;
    if (rd_used && (rd_addr != '0)) begin
      for (int k = STG_E; k <= NUM_STAGES; k++) begin
        if (!found && ent_valid[k-1] && (ent_addr[k-1] == rd_addr)) begin
          found  = 1'b1;
          sel    = SEL_W'(k);
          hazard = (int'(ent_ready[k-1]) > k);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding-select and interlock scoreboard for an in-order MIPS-style
// pipeline: shadows the destination of every instruction past D, steers
// each D read port to the nearest producer and stalls D when that
// producer (or the mult/div unit) is not ready yet.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int NUM_STAGES = 3,
  parameter  int MD_LATENCY = 5,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         d_valid,
  input  logic [REG_W*NUM_PORTS-1:0]   d_rd_addr,
  input  logic [NUM_PORTS-1:0]         d_rd_used,
  input  logic                         d_wr_en,
  input  logic [REG_W-1:0]             d_wr_addr,
  input  logic [2:0]                   d_wr_ready,
  input  logic                         d_md_start,
  input  logic                         d_md_use,
  input  logic                         hold,
  input  logic                         flush,
  output logic                         stall,
  output logic [SEL_W*NUM_PORTS-1:0]   fwd_sel,
  output logic                         md_busy
);

  localparam int MD_W = $clog2(MD_LATENCY + 1);

  stage_entry_t                     ent [1:NUM_STAGES];
  logic [NUM_STAGES-1:0]            ent_valid;
  logic [NUM_STAGES-1:0][REG_W-1:0] ent_addr;
  ready_t [NUM_STAGES-1:0]          ent_ready;
  logic [NUM_PORTS-1:0]             port_hazard;
  logic [MD_W-1:0]                  md_cnt;
  logic                             load_d;
  logic                             md_launch;

  // Flatten the shadow entries for the per-port search logic.
  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_flat
    assign ent_valid[k-1] = ent[k].valid;
    assign ent_addr[k-1]  = ent[k].wr_addr;
    assign ent_ready[k-1] = ent[k].ready;
  end

  // One producer search per D read port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fwd_port_sel #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
    ) u_sel (
      .rd_addr   (d_rd_addr[REG_W*p +: REG_W]),
      .rd_used   (d_rd_used[p]),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr),
      .ent_ready (ent_ready),
      .sel       (fwd_sel[SEL_W*p +: SEL_W]),
      .hazard    (port_hazard[p])
    );
  end

  // Interlock: a killed D instruction never stalls.
  assign md_busy   = (md_cnt != '0);
  assign stall     = d_valid & ~flush & ((|port_hazard) | (d_md_use & md_busy));
  assign load_d    = ~stall & ~flush;
  assign md_launch = ~hold & load_d & d_valid & d_md_start;

  // Shadow pipe: advance unless frozen; D enters E only when it really issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole shadow array is cleared, not just the valid bits, so
      // address/ready fields never carry X into the comparators after reset.
      for (int k = 1; k <= NUM_STAGES; k++) begin
        ent[k] <= '0;
      end
    end else if (!hold) begin
      if (load_d) begin
        ent[1] <= '{valid: d_valid & d_wr_en, wr_addr: d_wr_addr, ready: d_wr_ready};
      end else begin
        ent[1] <= '0;
      end
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value;
      // blocking here would ripple one entry through the whole chain in a cycle.
      for (int k = 2; k <= NUM_STAGES; k++) begin
        ent[k] <= ent[k-1];
      end
    end
  end

  // Mult/div busy counter: reload on issue, otherwise count down to zero even when frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (md_launch) begin
      md_cnt <= MD_W'(MD_LATENCY);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: default-parameter instance plus a
// 3-port / 5-stage instance, with per-cycle expectations queued as stimulus
// is driven and popped when outputs are sampled on the falling edge.
module tb_fwd_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [1:0] used;
    logic       wr_en;
    logic [4:0] wa;
    logic [2:0] wr_rdy;
    logic       md_start;
    logic       md_use;
    logic       hold;
    logic       flush;
  } drv_t;

  logic clk;
  logic rst_n;

  // Default instance (2 ports, 3 stages, latency 5)
  logic       d_valid, d_wr_en, d_md_start, d_md_use, hold, flush;
  logic [9:0] d_rd_addr;
  logic [1:0] d_rd_used;
  logic [4:0] d_wr_addr;
  logic [2:0] d_wr_ready;
  logic       stall, md_busy;
  logic [3:0] fwd_sel;

  // Wide instance (3 ports, 5 stages)
  logic        w_valid, w_wr_en;
  logic [14:0] w_rd_addr;
  logic [2:0]  w_rd_used;
  logic [4:0]  w_wr_addr;
  logic [2:0]  w_wr_ready;
  logic        w_stall, w_md_busy;
  logic [8:0]  w_fwd_sel;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  fwd_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_valid    (d_valid),
    .d_rd_addr  (d_rd_addr),
    .d_rd_used  (d_rd_used),
    .d_wr_en    (d_wr_en),
    .d_wr_addr  (d_wr_addr),
    .d_wr_ready (d_wr_ready),
    .d_md_start (d_md_start),
    .d_md_use   (d_md_use),
    .hold       (hold),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .md_busy    (md_busy)
  );

  fwd_scoreboard #(.NUM_PORTS(3), .NUM_STAGES(5), .MD_LATENCY(5)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_valid    (w_valid),
    .d_rd_addr  (w_rd_addr),
    .d_rd_used  (w_rd_used),
    .d_wr_en    (w_wr_en),
    .d_wr_addr  (w_wr_addr),
    .d_wr_ready (w_wr_ready),
    .d_md_start (1'b0),
    .d_md_use   (1'b0),
    .hold       (1'b0),
    .flush      (1'b0),
    .stall      (w_stall),
    .fwd_sel    (w_fwd_sel),
    .md_busy    (w_md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  function automatic drv_t wr(input logic [4:0] wa, input logic [2:0] rdy);
    drv_t s;
    s = '0;
    s.valid = 1'b1; s.wr_en = 1'b1; s.wa = wa; s.wr_rdy = rdy;
    return s;
  endfunction

  function automatic drv_t rd(input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] used);
    drv_t s;
    s = '0;
    s.valid = 1'b1; s.ra0 = ra0; s.ra1 = ra1; s.used = used;
    return s;
  endfunction

  // Expected {stall, md_busy, fwd_sel[1], fwd_sel[0]} for the default instance.
  function automatic logic [15:0] ex(input logic st, input logic bz, input logic [1:0] s1, input logic [1:0] s0);
    return {10'b0, st, bz, s1, s0};
  endfunction

  task automatic apply(input drv_t s);
    d_valid    = s.valid;
    d_rd_addr  = {s.ra1, s.ra0};
    d_rd_used  = s.used;
    d_wr_en    = s.wr_en;
    d_wr_addr  = s.wa;
    d_wr_ready = s.wr_rdy;
    d_md_start = s.md_start;
    d_md_use   = s.md_use;
    hold       = s.hold;
    flush      = s.flush;
  endtask

  task automatic w_idle();
    w_valid = 0; w_rd_addr = '0; w_rd_used = '0; w_wr_en = 0; w_wr_addr = '0; w_wr_ready = '0;
  endtask

  task automatic idle(input int n);
    apply('0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] e, o;
    apply(rd(5'd8, 5'd9, 2'b11));
    d_md_use = 1'b1;
    exp_q.push_back(ex(0, 0, 2'd0, 2'd0));
    @(negedge clk);
    e = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_held: got %b expected %b", o[5:0], e[5:0]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ex(0, 0, 2'd0, 2'd0));
    @(negedge clk);
    e = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_first_edge: got %b expected %b", o[5:0], e[5:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_hazard();
    drv_t s [3];
    logic [15:0] e [3];
    logic [15:0] ev, o;
    s[0] = wr(5'd8, 3'd2);            e[0] = ex(0, 0, 2'd0, 2'd0);
    s[1] = rd(5'd8, 5'd0, 2'b01);     e[1] = ex(1, 0, 2'd0, 2'd1);
    s[2] = rd(5'd8, 5'd0, 2'b01);     e[2] = ex(0, 0, 2'd0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL alu_hazard row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal_load();
    drv_t s [6];
    logic [15:0] e [6];
    logic [15:0] ev, o;
    s[0] = wr(5'd31, 3'd1);           e[0] = ex(0, 0, 2'd0, 2'd0);
    s[1] = rd(5'd31, 5'd0, 2'b01);    e[1] = ex(0, 0, 2'd0, 2'd1);
    s[2] = wr(5'd5, 3'd3);            e[2] = ex(0, 0, 2'd0, 2'd0);
    s[3] = rd(5'd0, 5'd5, 2'b10);     e[3] = ex(1, 0, 2'd1, 2'd0);
    s[4] = rd(5'd0, 5'd5, 2'b10);     e[4] = ex(1, 0, 2'd2, 2'd0);
    s[5] = rd(5'd0, 5'd5, 2'b10);     e[5] = ex(0, 0, 2'd3, 2'd0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL jal_load row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nearest_zero();
    drv_t s [4];
    logic [15:0] e [4];
    logic [15:0] ev, o;
    s[0] = wr(5'd9, 3'd2);            e[0] = ex(0, 0, 2'd0, 2'd0);
    s[1] = wr(5'd9, 3'd1);            e[1] = ex(0, 0, 2'd0, 2'd0);
    s[2] = rd(5'd9, 5'd0, 2'b01);
    s[2].wr_en = 1'b1; s[2].wa = 5'd0; s[2].wr_rdy = 3'd3;
                                      e[2] = ex(0, 0, 2'd0, 2'd1);
    s[3] = rd(5'd0, 5'd0, 2'b11);     e[3] = ex(0, 0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL nearest_zero row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md_interlock();
    drv_t s [7];
    logic [15:0] e [7];
    logic [15:0] ev, o;
    s[0] = rd(5'd0, 5'd0, 2'b00); s[0].md_start = 1'b1; s[0].md_use = 1'b1;
    e[0] = ex(0, 0, 2'd0, 2'd0);
    for (int i = 1; i < 7; i++) begin
      s[i] = rd(5'd0, 5'd0, 2'b00); s[i].md_use = 1'b1;
      e[i] = (i <= 5) ? ex(1, 1, 2'd0, 2'd0) : ex(0, 0, 2'd0, 2'd0);
    end
    for (int i = 0; i < 7; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL md_interlock row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_flush();
    drv_t s [10];
    logic [15:0] e [10];
    logic [15:0] ev, o;
    s[0] = wr(5'd5, 3'd3); s[0].md_start = 1'b1; e[0] = ex(0, 0, 2'd0, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      s[i] = rd(5'd5, 5'd0, 2'b01); s[i].hold = 1'b1;
      e[i] = ex(1, 1, 2'd0, 2'd1);
    end
    s[4] = rd(5'd5, 5'd0, 2'b01);     e[4] = ex(1, 1, 2'd0, 2'd1);
    s[5] = rd(5'd5, 5'd0, 2'b01);     e[5] = ex(1, 1, 2'd0, 2'd2);
    s[6] = rd(5'd5, 5'd0, 2'b01);     e[6] = ex(0, 0, 2'd0, 2'd3);
    s[7] = wr(5'd8, 3'd2);            e[7] = ex(0, 0, 2'd0, 2'd0);
    s[8] = rd(5'd8, 5'd0, 2'b01);
    s[8].wr_en = 1'b1; s[8].wa = 5'd10; s[8].wr_rdy = 3'd2; s[8].flush = 1'b1;
                                      e[8] = ex(0, 0, 2'd0, 2'd1);
    s[9] = rd(5'd10, 5'd8, 2'b11);    e[9] = ex(0, 0, 2'd2, 2'd0);
    for (int i = 0; i < 10; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL hold_flush row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_md();
    drv_t s [4];
    logic [15:0] e [4];
    logic [15:0] ev, o;
    s[0] = wr(5'd1, 3'd3); s[0].md_start = 1'b1; e[0] = ex(0, 0, 2'd0, 2'd0);
    s[1] = wr(5'd2, 3'd3);            e[1] = ex(0, 1, 2'd0, 2'd0);
    s[2] = wr(5'd3, 3'd3);            e[2] = ex(0, 1, 2'd0, 2'd0);
    s[3] = rd(5'd3, 5'd2, 2'b11); s[3].md_use = 1'b1;
                                      e[3] = ex(1, 1, 2'd2, 2'd1);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL reset_mid row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // Pulse reset with the hazard-causing D instruction still applied.
    #2 rst_n = 1'b0;
    exp_q.push_back(ex(0, 0, 2'd0, 2'd0));
    #1;
    ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
    checks++;
    if (o !== ev) begin errors++; $display("FAIL reset_mid_async: got %b expected %b", o[5:0], ev[5:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(ex(0, 0, 2'd0, 2'd0));
      @(negedge clk);
      ev = exp_q.pop_front(); o = {10'b0, stall, md_busy, fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL reset_mid_after row %0d: got %b expected %b", i, o[5:0], ev[5:0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    logic [14:0] ra   [7];
    logic [2:0]  used [7];
    logic        wen  [7];
    logic [15:0] e    [7];
    logic [15:0] ev, o;
    // Row 0 writes $8 (ALU); later rows read $8 and watch it walk to stage 5.
    ra[0] = '0;                    used[0] = 3'b000; wen[0] = 1; e[0] = {5'b0, 2'b00, 3'd0, 3'd0, 3'd0};
    ra[1] = {5'd8, 5'd0, 5'd8};    used[1] = 3'b101; wen[1] = 0; e[1] = {5'b0, 2'b10, 3'd1, 3'd0, 3'd1};
    ra[2] = {5'd8, 5'd0, 5'd8};    used[2] = 3'b101; wen[2] = 0; e[2] = {5'b0, 2'b00, 3'd2, 3'd0, 3'd2};
    ra[3] = {5'd8, 5'd0, 5'd0};    used[3] = 3'b100; wen[3] = 0; e[3] = {5'b0, 2'b00, 3'd3, 3'd0, 3'd0};
    ra[4] = {5'd8, 5'd0, 5'd0};    used[4] = 3'b100; wen[4] = 0; e[4] = {5'b0, 2'b00, 3'd4, 3'd0, 3'd0};
    ra[5] = {5'd8, 5'd0, 5'd0};    used[5] = 3'b100; wen[5] = 0; e[5] = {5'b0, 2'b00, 3'd5, 3'd0, 3'd0};
    ra[6] = {5'd8, 5'd0, 5'd0};    used[6] = 3'b100; wen[6] = 0; e[6] = {5'b0, 2'b00, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 7; i++) begin
      w_valid = 1'b1; w_rd_addr = ra[i]; w_rd_used = used[i];
      w_wr_en = wen[i]; w_wr_addr = 5'd8; w_wr_ready = 3'd2;
      exp_q.push_back(e[i]);
      @(negedge clk);
      ev = exp_q.pop_front(); o = {5'b0, w_stall, w_md_busy, w_fwd_sel};
      checks++;
      if (o !== ev) begin errors++; $display("FAIL wide row %0d: got %b expected %b", i, o[10:0], ev[10:0]); end
      @(posedge clk); #1;
    end
    w_idle();
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    apply('0);
    w_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu_hazard();     idle(6);
    test_jal_load();       idle(6);
    test_nearest_zero();   idle(6);
    test_md_interlock();   idle(6);
    test_hold_flush();     idle(6);
    test_reset_mid_md();   idle(6);
    test_wide();           idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
